// File: rtl/idma_legalizer_rw_axi_split.sv
// Splits buffered 1D transfers into page-safe AXI4 INCR read/write bursts,
// with per-transfer coupled or decoupled R/W issue and ready-independent valids.
module idma_legalizer_rw_axi_split #(
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned LenWidth     = 32,
  parameter int unsigned MaxBeats     = 256,
  parameter int unsigned PageSize     = 4096,
  parameter int unsigned ReqFifoDepth = 2,
  localparam int unsigned StrbWidth   = DataWidth / 8,
  localparam int unsigned OffsetWidth = $clog2(StrbWidth)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [AddrWidth-1:0]   req_src_addr_i,
  input  logic [AddrWidth-1:0]   req_dst_addr_i,
  input  logic [LenWidth-1:0]    req_length_i,
  input  logic                   req_decouple_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  output logic [AddrWidth-1:0]   r_addr_o,
  output logic [7:0]             r_len_o,
  output logic [OffsetWidth-1:0] r_offset_o,
  output logic [OffsetWidth-1:0] r_tailer_o,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [AddrWidth-1:0]   w_addr_o,
  output logic [7:0]             w_len_o,
  output logic [OffsetWidth-1:0] w_offset_o,
  output logic [OffsetWidth-1:0] w_tailer_o,
  output logic                   w_last_o,
  output logic                   w_valid_o,
  input  logic                   w_ready_i,
  input  logic                   kill_i,
  output logic                   busy_o
);

  localparam int unsigned BurstBytes = MaxBeats * StrbWidth;
  localparam int unsigned Chunk      = (PageSize < BurstBytes) ? PageSize : BurstBytes;
  localparam int unsigned ChunkW     = $clog2(Chunk) + 1;
  localparam int unsigned PtrW       = (ReqFifoDepth > 1) ? $clog2(ReqFifoDepth) : 1;
  localparam int unsigned CntW       = $clog2(ReqFifoDepth + 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} eng_state_e;

  typedef struct packed {
    logic [AddrWidth-1:0] src;
    logic [AddrWidth-1:0] dst;
    logic [LenWidth-1:0]  len;
    logic                 decouple;
  } req_t;

  req_t            r_fifo [ReqFifoDepth];
  logic [PtrW-1:0] r_wptr, r_rptr;
  logic [CntW-1:0] r_cnt;
  logic            w_full, w_empty, w_push, w_pop;
  req_t            w_head;

  eng_state_e           r_rd_state, r_wr_state, w_rd_state_nx, w_wr_state_nx;
  logic [AddrWidth-1:0] r_rd_addr, r_wr_addr, w_rd_addr_nx, w_wr_addr_nx;
  logic [LenWidth-1:0]  r_rd_rem, r_wr_rem, w_rd_rem_nx, w_wr_rem_nx;
  logic                 r_rd_iss, r_wr_iss, w_rd_iss_nx, w_wr_iss_nx;
  logic                 r_dec, w_dec_nx;

  logic [ChunkW-1:0] w_rd_pb, w_wr_pb, w_rd_lim, w_wr_lim, w_rd_num, w_wr_num, w_rd_sum, w_wr_sum;
  logic w_rd_act, w_wr_act, w_rd_valid, w_wr_valid, w_rd_hs, w_wr_hs;
  logic w_rd_last, w_wr_last, w_adv_cpl, w_adv_rd, w_adv_wr;
  logic w_rd_free, w_wr_free, w_load, w_start;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(ReqFifoDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign w_full      = (r_cnt == CntW'(ReqFifoDepth));
  assign w_empty     = (r_cnt == '0);
  assign req_ready_o = ~w_full;
  assign w_push      = req_valid_i & ~w_full;
  assign w_pop       = w_load;
  assign w_head      = r_fifo[r_rptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < int'(ReqFifoDepth); i++) r_fifo[i] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= '{src: req_src_addr_i, dst: req_dst_addr_i,
                            len: req_length_i, decouple: req_decouple_i};
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CntW'(1);
        2'b01:   r_cnt <= r_cnt - CntW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Burst sizing: distance to the next chunk boundary, shared in coupled mode.
  always_comb begin
    w_rd_pb  = ChunkW'(Chunk) - {1'b0, r_rd_addr[ChunkW-2:0]};
    w_wr_pb  = ChunkW'(Chunk) - {1'b0, r_wr_addr[ChunkW-2:0]};
    w_rd_lim = w_rd_pb;
    w_wr_lim = w_wr_pb;
    if (!r_dec) begin
      w_rd_lim = (w_rd_pb < w_wr_pb) ? w_rd_pb : w_wr_pb;
      w_wr_lim = w_rd_lim;
    end else begin
      w_rd_lim = w_rd_pb;
      w_wr_lim = w_wr_pb;
    end
    w_rd_num = (r_rd_rem < LenWidth'(w_rd_lim)) ? ChunkW'(r_rd_rem) : w_rd_lim;
    w_wr_num = (r_wr_rem < LenWidth'(w_wr_lim)) ? ChunkW'(r_wr_rem) : w_wr_lim;
    w_rd_sum = w_rd_num + ChunkW'(r_rd_addr[OffsetWidth-1:0]);
    w_wr_sum = w_wr_num + ChunkW'(r_wr_addr[OffsetWidth-1:0]);
  end

  assign w_rd_act   = (r_rd_state == ACTIVE);
  assign w_wr_act   = (r_wr_state == ACTIVE);
  assign w_rd_valid = w_rd_act & ~r_rd_iss;
  assign w_wr_valid = w_wr_act & ~r_wr_iss;
  assign w_rd_hs    = w_rd_valid & r_ready_i;
  assign w_wr_hs    = w_wr_valid & w_ready_i;
  assign w_rd_last  = (r_rd_rem == LenWidth'(w_rd_num));
  assign w_wr_last  = (r_wr_rem == LenWidth'(w_wr_num));
  assign w_adv_cpl  = ~r_dec & w_rd_act & w_wr_act & (r_rd_iss | w_rd_hs) & (r_wr_iss | w_wr_hs);
  assign w_adv_rd   = r_dec ? w_rd_hs : w_adv_cpl;
  assign w_adv_wr   = r_dec ? w_wr_hs : w_adv_cpl;
  assign w_rd_free  = ~w_rd_act | (w_adv_rd & w_rd_last);
  assign w_wr_free  = ~w_wr_act | (w_adv_wr & w_wr_last);
  assign w_load     = ~w_empty & w_rd_free & w_wr_free & ~kill_i;
  assign w_start    = w_load & (w_head.len != '0);

  // Engine next-state: kill wins, then a fresh load overrides the finishing burst.
  always_comb begin
    w_rd_state_nx = r_rd_state;
    w_wr_state_nx = r_wr_state;
    w_rd_addr_nx  = r_rd_addr;
    w_wr_addr_nx  = r_wr_addr;
    w_rd_rem_nx   = r_rd_rem;
    w_wr_rem_nx   = r_wr_rem;
    w_rd_iss_nx   = r_rd_iss;
    w_wr_iss_nx   = r_wr_iss;
    w_dec_nx      = r_dec;
    if (kill_i) begin
      w_rd_state_nx = IDLE;
      w_wr_state_nx = IDLE;
      w_rd_iss_nx   = 1'b0;
      w_wr_iss_nx   = 1'b0;
    end else begin
      if (w_adv_rd) begin
        w_rd_addr_nx  = r_rd_addr + AddrWidth'(w_rd_num);
        w_rd_rem_nx   = r_rd_rem - LenWidth'(w_rd_num);
        w_rd_state_nx = w_rd_last ? IDLE : ACTIVE;
      end else begin
        w_rd_state_nx = r_rd_state;
      end
      if (w_adv_wr) begin
        w_wr_addr_nx  = r_wr_addr + AddrWidth'(w_wr_num);
        w_wr_rem_nx   = r_wr_rem - LenWidth'(w_wr_num);
        w_wr_state_nx = w_wr_last ? IDLE : ACTIVE;
      end else begin
        w_wr_state_nx = r_wr_state;
      end
      if (w_adv_cpl) begin
        w_rd_iss_nx = 1'b0;
        w_wr_iss_nx = 1'b0;
      end else begin
        w_rd_iss_nx = r_rd_iss | (~r_dec & w_rd_hs);
        w_wr_iss_nx = r_wr_iss | (~r_dec & w_wr_hs);
      end
      if (w_start) begin
        w_rd_state_nx = ACTIVE;
        w_wr_state_nx = ACTIVE;
        w_rd_addr_nx  = w_head.src;
        w_wr_addr_nx  = w_head.dst;
        w_rd_rem_nx   = w_head.len;
        w_wr_rem_nx   = w_head.len;
        w_dec_nx      = w_head.decouple;
      end else begin
        w_dec_nx = r_dec;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_state <= IDLE;
      r_wr_state <= IDLE;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_rd_rem   <= '0;
      r_wr_rem   <= '0;
      r_rd_iss   <= 1'b0;
      r_wr_iss   <= 1'b0;
      r_dec      <= 1'b0;
    end else begin
      r_rd_state <= w_rd_state_nx;
      r_wr_state <= w_wr_state_nx;
      r_rd_addr  <= w_rd_addr_nx;
      r_wr_addr  <= w_wr_addr_nx;
      r_rd_rem   <= w_rd_rem_nx;
      r_wr_rem   <= w_wr_rem_nx;
      r_rd_iss   <= w_rd_iss_nx;
      r_wr_iss   <= w_wr_iss_nx;
      r_dec      <= w_dec_nx;
    end
  end

  // Fields are forced to zero while idle so the reset/idle view is clean.
  assign r_valid_o  = w_rd_valid;
  assign r_addr_o   = w_rd_act ? {r_rd_addr[AddrWidth-1:OffsetWidth], {OffsetWidth{1'b0}}} : '0;
  assign r_len_o    = w_rd_act ? 8'((w_rd_sum - ChunkW'(1)) >> OffsetWidth) : 8'd0;
  assign r_offset_o = w_rd_act ? r_rd_addr[OffsetWidth-1:0] : '0;
  assign r_tailer_o = w_rd_act ? w_rd_sum[OffsetWidth-1:0] : '0;

  assign w_valid_o  = w_wr_valid;
  assign w_addr_o   = w_wr_act ? {r_wr_addr[AddrWidth-1:OffsetWidth], {OffsetWidth{1'b0}}} : '0;
  assign w_len_o    = w_wr_act ? 8'((w_wr_sum - ChunkW'(1)) >> OffsetWidth) : 8'd0;
  assign w_offset_o = w_wr_act ? r_wr_addr[OffsetWidth-1:0] : '0;
  assign w_tailer_o = w_wr_act ? w_wr_sum[OffsetWidth-1:0] : '0;
  assign w_last_o   = w_wr_act & w_wr_last;

  assign busy_o = ~w_empty | w_rd_act | w_wr_act;

endmodule

// File: tb/tb_idma_legalizer_rw_axi_split.sv
// Directed bench for idma_legalizer_rw_axi_split (64-bit bus, 2 KiB chunk).
module tb_idma_legalizer_rw_axi_split;

  logic        clk, rst;
  logic [31:0] req_src, req_dst, req_len;
  logic        req_dec, req_valid, req_ready;
  logic [31:0] r_addr, w_addr;
  logic [7:0]  r_len, w_len;
  logic [2:0]  r_off, r_tail, w_off, w_tail;
  logic        r_valid, r_ready, w_valid, w_ready, w_last, kill, busy;

  int n_pass  = 0;
  int n_total = 0;

  idma_legalizer_rw_axi_split dut (
    .clk_i(clk), .rst_i(rst),
    .req_src_addr_i(req_src), .req_dst_addr_i(req_dst), .req_length_i(req_len),
    .req_decouple_i(req_dec), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .r_addr_o(r_addr), .r_len_o(r_len), .r_offset_o(r_off), .r_tailer_o(r_tail),
    .r_valid_o(r_valid), .r_ready_i(r_ready),
    .w_addr_o(w_addr), .w_len_o(w_len), .w_offset_o(w_off), .w_tailer_o(w_tail),
    .w_last_o(w_last), .w_valid_o(w_valid), .w_ready_i(w_ready),
    .kill_i(kill), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l, input logic dec);
    req_src = s; req_dst = d; req_len = l; req_dec = dec; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; kill = 1'b0; req_valid = 1'b0; req_dec = 1'b0;
    req_src = 32'd0; req_dst = 32'd0; req_len = 32'd0;
    r_ready = 1'b1; w_ready = 1'b1;
    tick(); tick();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_r_valid", {31'd0, r_valid}, 32'd0);
    chk("rst_w_valid", {31'd0, w_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_r_len", {24'd0, r_len}, 32'd0);
    chk("rst_w_addr", w_addr, 32'd0);
    rst = 1'b0;
    tick();

    // coupled 4 KiB from 0: two full 256-beat bursts
    push(32'h0, 32'h0, 32'd4096, 1'b0);
    chk("t1_pre_valid", {31'd0, r_valid}, 32'd0);
    chk("t1_pre_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_b1_r_valid", {31'd0, r_valid}, 32'd1);
    chk("t1_b1_w_valid", {31'd0, w_valid}, 32'd1);
    chk("t1_b1_r_addr", r_addr, 32'h0);
    chk("t1_b1_r_len", {24'd0, r_len}, 32'd255);
    chk("t1_b1_w_len", {24'd0, w_len}, 32'd255);
    chk("t1_b1_w_last", {31'd0, w_last}, 32'd0);
    tick();
    chk("t1_b2_r_addr", r_addr, 32'h800);
    chk("t1_b2_w_addr", w_addr, 32'h800);
    chk("t1_b2_r_len", {24'd0, r_len}, 32'd255);
    chk("t1_b2_w_last", {31'd0, w_last}, 32'd1);
    tick();
    chk("t1_end_r_valid", {31'd0, r_valid}, 32'd0);
    chk("t1_end_busy", {31'd0, busy}, 32'd0);

    // coupled page-crossing with unaligned source
    push(32'hFFC, 32'h1000, 32'd16, 1'b0);
    tick();
    chk("t2_b1_r_addr", r_addr, 32'hFF8);
    chk("t2_b1_r_len", {24'd0, r_len}, 32'd0);
    chk("t2_b1_r_off", {29'd0, r_off}, 32'd4);
    chk("t2_b1_r_tail", {29'd0, r_tail}, 32'd0);
    chk("t2_b1_w_addr", w_addr, 32'h1000);
    chk("t2_b1_w_len", {24'd0, w_len}, 32'd0);
    chk("t2_b1_w_off", {29'd0, w_off}, 32'd0);
    chk("t2_b1_w_tail", {29'd0, w_tail}, 32'd4);
    chk("t2_b1_w_last", {31'd0, w_last}, 32'd0);
    tick();
    chk("t2_b2_r_addr", r_addr, 32'h1000);
    chk("t2_b2_r_len", {24'd0, r_len}, 32'd1);
    chk("t2_b2_r_tail", {29'd0, r_tail}, 32'd4);
    chk("t2_b2_w_addr", w_addr, 32'h1000);
    chk("t2_b2_w_off", {29'd0, w_off}, 32'd4);
    chk("t2_b2_w_len", {24'd0, w_len}, 32'd1);
    chk("t2_b2_w_tail", {29'd0, w_tail}, 32'd0);
    chk("t2_b2_w_last", {31'd0, w_last}, 32'd1);
    tick();
    chk("t2_end_busy", {31'd0, busy}, 32'd0);

    // same transfer decoupled: W needs only one burst
    push(32'hFFC, 32'h1000, 32'd16, 1'b1);
    tick();
    chk("t3_b1_r_addr", r_addr, 32'hFF8);
    chk("t3_b1_r_len", {24'd0, r_len}, 32'd0);
    chk("t3_w_valid", {31'd0, w_valid}, 32'd1);
    chk("t3_w_addr", w_addr, 32'h1000);
    chk("t3_w_len", {24'd0, w_len}, 32'd1);
    chk("t3_w_tail", {29'd0, w_tail}, 32'd0);
    chk("t3_w_last", {31'd0, w_last}, 32'd1);
    tick();
    chk("t3_b2_r_valid", {31'd0, r_valid}, 32'd1);
    chk("t3_b2_r_addr", r_addr, 32'h1000);
    chk("t3_b2_r_len", {24'd0, r_len}, 32'd1);
    chk("t3_b2_r_tail", {29'd0, r_tail}, 32'd4);
    chk("t3_b2_w_valid", {31'd0, w_valid}, 32'd0);
    tick();
    chk("t3_end_busy", {31'd0, busy}, 32'd0);

    // coupled with W back-pressure: R issues once and waits
    w_ready = 1'b0;
    push(32'hFFC, 32'h1000, 32'd16, 1'b0);
    tick();
    chk("t4_r_valid0", {31'd0, r_valid}, 32'd1);
    chk("t4_w_valid0", {31'd0, w_valid}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t4_hold%0d_r_valid", i), {31'd0, r_valid}, 32'd0);
      chk($sformatf("t4_hold%0d_w_valid", i), {31'd0, w_valid}, 32'd1);
      chk($sformatf("t4_hold%0d_w_addr", i), w_addr, 32'h1000);
      chk($sformatf("t4_hold%0d_w_tail", i), {29'd0, w_tail}, 32'd4);
    end
    w_ready = 1'b1;
    tick();
    chk("t4_b2_r_valid", {31'd0, r_valid}, 32'd1);
    chk("t4_b2_r_addr", r_addr, 32'h1000);
    chk("t4_b2_r_len", {24'd0, r_len}, 32'd1);
    chk("t4_b2_w_off", {29'd0, w_off}, 32'd4);
    chk("t4_b2_w_last", {31'd0, w_last}, 32'd1);
    tick();
    chk("t4_end_w_valid", {31'd0, w_valid}, 32'd0);

    // kill mid-transfer with a second request queued behind it
    push(32'h0, 32'h0, 32'd8192, 1'b0);
    push(32'h100, 32'h200, 32'd8, 1'b0);
    tick();
    chk("t5_b2_r_addr", r_addr, 32'h800);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    chk("t5_kill_r_valid", {31'd0, r_valid}, 32'd0);
    chk("t5_kill_w_valid", {31'd0, w_valid}, 32'd0);
    chk("t5_kill_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("t5_next_r_valid", {31'd0, r_valid}, 32'd1);
    chk("t5_next_r_addr", r_addr, 32'h100);
    chk("t5_next_w_addr", w_addr, 32'h200);
    chk("t5_next_r_len", {24'd0, r_len}, 32'd0);
    chk("t5_next_w_len", {24'd0, w_len}, 32'd0);
    chk("t5_next_w_last", {31'd0, w_last}, 32'd1);
    tick();
    chk("t5_end_busy", {31'd0, busy}, 32'd0);

    // zero-length request is discarded
    push(32'h40, 32'h80, 32'd0, 1'b0);
    chk("t6_busy_queued", {31'd0, busy}, 32'd1);
    tick();
    chk("t6_r_valid", {31'd0, r_valid}, 32'd0);
    chk("t6_w_valid", {31'd0, w_valid}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);

    // reset mid-burst with another entry queued
    push(32'h0, 32'h0, 32'd4096, 1'b0);
    push(32'h40, 32'h40, 32'd64, 1'b0);
    chk("t7_pre_r_valid", {31'd0, r_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t7_rst_r_valid", {31'd0, r_valid}, 32'd0);
    chk("t7_rst_w_valid", {31'd0, w_valid}, 32'd0);
    chk("t7_rst_busy", {31'd0, busy}, 32'd0);
    chk("t7_rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("t7_rst_r_len", {24'd0, r_len}, 32'd0);
    chk("t7_rst_w_last", {31'd0, w_last}, 32'd0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("t7_after_r_valid", {31'd0, r_valid}, 32'd0);
    chk("t7_after_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
